// File: rtl/controle_mc_param_if.sv
// Handshake/control bundle between the multi-cycle control unit and its datapath.
// The control unit sits on the slave side; the datapath/driver sits on the master side.
interface controle_mc_param_if #(
    parameter int unsigned RSEL_W = 3,
    parameter int unsigned NREG   = 7
);
    localparam int unsigned IR_W = 4 + 2 * RSEL_W;

    logic              run;
    logic [IR_W-1:0]   IR;
    logic              G_or;
    logic              mem_ready;

    logic              IR_in;
    logic              ADDR_in;
    logic              DOUT_in;
    logic              W_D;
    logic              G_in;
    logic              A_in;
    logic              incr_PC;
    logic [1:0]        mux_control;
    logic [3:0]        ULA_control;
    logic [NREG-1:0]   register_in;
    logic [RSEL_W-1:0] register_out;
    logic              mem_wait;
    logic              instr_done;
    logic              illegal;

    modport master (
        output run, IR, G_or, mem_ready,
        input  IR_in, ADDR_in, DOUT_in, W_D, G_in, A_in, incr_PC,
               mux_control, ULA_control, register_in, register_out,
               mem_wait, instr_done, illegal
    );

    modport slave (
        input  run, IR, G_or, mem_ready,
        output IR_in, ADDR_in, DOUT_in, W_D, G_in, A_in, incr_PC,
               mux_control, ULA_control, register_in, register_out,
               mem_wait, instr_done, illegal
    );
endinterface

// File: rtl/controle_mc_param.sv
// Parametrised multi-cycle control unit: decodes {opcode, Rx, Ry} and sequences T0..T3,
// with memory-ready stalls, run/hold, an instruction-done pulse and illegal-opcode flagging.
module controle_mc_param #(
    parameter int unsigned RSEL_W   = 3,
    parameter int unsigned NREG     = 7,
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic                clock,
    input  logic                reset,
    controle_mc_param_if.slave  bus
);
    localparam int unsigned IR_W = 4 + 2 * RSEL_W;

    localparam logic [3:0] OP_LD   = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0001;
    localparam logic [3:0] OP_MVNZ = 4'b0010;
    localparam logic [3:0] OP_MV   = 4'b0011;
    localparam logic [3:0] OP_MVI  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b1010;

    localparam logic [1:0] MUX_DIN = 2'b00;
    localparam logic [1:0] MUX_REG = 2'b01;
    localparam logic [1:0] MUX_PC  = 2'b10;
    localparam logic [1:0] MUX_G   = 2'b11;

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    step_t step_q, step_d;

    logic [3:0]        opcode;
    logic [RSEL_W-1:0] rx;
    logic [RSEL_W-1:0] ry;
    logic              is_alu;
    logic              ready;
    logic              done;
    logic              stall;
    logic [NREG-1:0]   rx_onehot;

    assign opcode = bus.IR[IR_W-1 -: 4];
    assign rx     = bus.IR[2*RSEL_W-1 -: RSEL_W];
    assign ry     = bus.IR[RSEL_W-1:0];
    assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_SRL);
    assign ready  = (MEM_WAIT == 0) || bus.mem_ready;

    // Rx decode; indices at or above NREG leave every write enable low.
    always_comb begin
        rx_onehot = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rx == RSEL_W'(i)) rx_onehot[i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) step_q <= T0;
        else       step_q <= step_d;
    end

    // Per-step decode; everything is forced low in reset or while run is low.
    always_comb begin
        bus.IR_in        = 1'b0;
        bus.ADDR_in      = 1'b0;
        bus.DOUT_in      = 1'b0;
        bus.W_D          = 1'b0;
        bus.G_in         = 1'b0;
        bus.A_in         = 1'b0;
        bus.incr_PC      = 1'b0;
        bus.mux_control  = MUX_DIN;
        bus.ULA_control  = 4'b0000;
        bus.register_in  = '0;
        bus.register_out = '0;
        bus.illegal      = 1'b0;
        done             = 1'b0;
        stall            = 1'b0;

        if (!reset && bus.run) begin
            unique case (step_q)
                T0: begin
                    bus.IR_in   = 1'b1;
                    bus.incr_PC = 1'b1;
                end
                T1: begin
                    if (is_alu) begin
                        bus.mux_control  = MUX_REG;
                        bus.register_out = rx;
                        bus.A_in         = 1'b1;
                    end else begin
                        case (opcode)
                            OP_MV: begin
                                bus.mux_control  = MUX_REG;
                                bus.register_out = ry;
                                bus.register_in  = rx_onehot;
                                done             = 1'b1;
                            end
                            OP_MVNZ: begin
                                if (bus.G_or) begin
                                    bus.mux_control  = MUX_REG;
                                    bus.register_out = ry;
                                    bus.register_in  = rx_onehot;
                                end
                                done = 1'b1;
                            end
                            OP_LD, OP_ST: begin
                                bus.mux_control  = MUX_REG;
                                bus.register_out = ry;
                                bus.ADDR_in      = 1'b1;
                            end
                            OP_MVI: begin
                                bus.mux_control = MUX_PC;
                                bus.ADDR_in     = 1'b1;
                            end
                            default: begin
                                bus.illegal = 1'b1;
                                done        = 1'b1;
                            end
                        endcase
                    end
                end
                T2: begin
                    if (is_alu) begin
                        bus.mux_control  = MUX_REG;
                        bus.register_out = ry;
                        bus.ULA_control  = opcode;
                        bus.G_in         = 1'b1;
                    end else begin
                        case (opcode)
                            OP_LD: begin
                                bus.mux_control = MUX_DIN;
                                if (ready) begin
                                    bus.register_in = rx_onehot;
                                    done            = 1'b1;
                                end else begin
                                    stall = 1'b1;
                                end
                            end
                            OP_ST: begin
                                bus.mux_control  = MUX_REG;
                                bus.register_out = rx;
                                if (ready) begin
                                    bus.DOUT_in = 1'b1;
                                    bus.W_D     = 1'b1;
                                    done        = 1'b1;
                                end else begin
                                    stall = 1'b1;
                                end
                            end
                            OP_MVI: begin
                                bus.mux_control = MUX_DIN;
                                if (ready) begin
                                    bus.register_in = rx_onehot;
                                    bus.incr_PC     = 1'b1;
                                    done            = 1'b1;
                                end else begin
                                    stall = 1'b1;
                                end
                            end
                            // IR changed under a short instruction: retire back to fetch.
                            default: done = 1'b1;
                        endcase
                    end
                end
                T3: begin
                    if (is_alu) begin
                        bus.mux_control = MUX_G;
                        bus.register_in = rx_onehot;
                    end
                    done = 1'b1;
                end
                default: ;
            endcase
        end

        bus.mem_wait   = stall;
        bus.instr_done = done;
    end

    // Next step: hold when not running or stalled, return to T0 on completion.
    always_comb begin
        step_d = step_q;
        if (!bus.run || stall) step_d = step_q;
        else if (done)         step_d = T0;
        else                   step_d = step_t'(2'(step_q) + 2'd1);
    end
endmodule

// File: tb/tb_controle_mc_param.sv
// Directed scoreboard bench: two builds (3-bit/7-reg with memory wait, 4-bit/15-reg without).
module tb_controle_mc_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    controle_mc_param_if #(.RSEL_W(3), .NREG(7))  ia ();
    controle_mc_param_if #(.RSEL_W(4), .NREG(15)) ib ();

    controle_mc_param #(.RSEL_W(3), .NREG(7), .MEM_WAIT(1)) dut_a (
        .clock(clock), .reset(reset), .bus(ia.slave)
    );
    controle_mc_param #(.RSEL_W(4), .NREG(15), .MEM_WAIT(0)) dut_b (
        .clock(clock), .reset(reset), .bus(ib.slave)
    );

    typedef struct {
        string       tag;
        bit          sel;
        logic [35:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks      = 0;
    int   failures    = 0;
    int   wait_cycles = 0;

    function automatic logic [35:0] mk(
        input logic ir_in, input logic addr_in, input logic dout_in, input logic wd,
        input logic gin, input logic ain, input logic inc,
        input logic [1:0] mux, input logic [3:0] ula, input logic [15:0] rin,
        input logic [3:0] rout, input logic mw, input logic dn, input logic ill);
        return {ir_in, addr_in, dout_in, wd, gin, ain, inc, mux, ula, rin, rout, mw, dn, ill};
    endfunction

    function automatic logic [35:0] t0();
        return mk(1, 0, 0, 0, 0, 0, 1, 2'b00, 4'd0, 16'd0, 4'd0, 0, 0, 0);
    endfunction

    logic [35:0] obs_a, obs_b;
    always_comb obs_a = mk(ia.IR_in, ia.ADDR_in, ia.DOUT_in, ia.W_D, ia.G_in, ia.A_in,
                           ia.incr_PC, ia.mux_control, ia.ULA_control, 16'(ia.register_in),
                           4'(ia.register_out), ia.mem_wait, ia.instr_done, ia.illegal);
    always_comb obs_b = mk(ib.IR_in, ib.ADDR_in, ib.DOUT_in, ib.W_D, ib.G_in, ib.A_in,
                           ib.incr_PC, ib.mux_control, ib.ULA_control, 16'(ib.register_in),
                           ib.register_out, ib.mem_wait, ib.instr_done, ib.illegal);

    // Pop one expectation per cycle, mid-period, once inputs and outputs have settled.
    always @(negedge clock) begin
        if (ia.mem_wait === 1'b1) wait_cycles++;
        if (sb.size() > 0) begin
            exp_t e;
            logic [35:0] o;
            e = sb.pop_front();
            o = e.sel ? obs_b : obs_a;
            checks++;
            assert (o === e.v) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
            end
        end
    end

    task automatic check_now(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic step(input string tag, input bit sel, input logic [35:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = v;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        ia.run = 1'b1; ia.IR = 10'b0101_001_010; ia.G_or = 1'b0; ia.mem_ready = 1'b1;
        ib.run = 1'b0; ib.IR = '0;               ib.G_or = 1'b0; ib.mem_ready = 1'b0;
        @(posedge clock);
        #1;

        step("rst0", 0, 36'd0);
        step("rst1", 0, 36'd0);
        check_now("rst_state", (obs_a === 36'd0) && (obs_b === 36'd0));
        reset = 1'b0;

        // ADD R1,R2 (mem_ready high throughout, must be ignored)
        step("add_t0", 0, t0());
        step("add_t1", 0, mk(0, 0, 0, 0, 0, 1, 0, 2'b01, 4'd0, 16'd0, 4'd1, 0, 0, 0));
        step("add_t2", 0, mk(0, 0, 0, 0, 1, 0, 0, 2'b01, 4'b0101, 16'd0, 4'd2, 0, 0, 0));
        step("add_t3", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 4'd0, 16'h0002, 4'd0, 0, 1, 0));

        // LD R3,[R5] with three stall cycles
        ia.IR = 10'b0000_011_101; ia.mem_ready = 1'b0;
        wait_cycles = 0;
        step("ld_t0", 0, t0());
        step("ld_t1", 0, mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 4'd0, 16'd0, 4'd5, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step("ld_stall", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'd0, 4'd0, 1, 0, 0));
        ia.mem_ready = 1'b1;
        step("ld_t2", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0008, 4'd0, 0, 1, 0));
        check_now("ld_wait_expired", wait_cycles == 3);

        // MVNZ R6,R0 with G_or low, then high
        ia.IR = 10'b0010_110_000; ia.G_or = 1'b0;
        step("mvnz0_t0", 0, t0());
        step("mvnz0_t1", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'd0, 4'd0, 0, 1, 0));
        ia.G_or = 1'b1;
        step("mvnz1_t0", 0, t0());
        step("mvnz1_t1", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 4'd0, 16'h0040, 4'd0, 0, 1, 0));

        // MV R7,R1: Rx out of range, no write but completes
        ia.IR = 10'b0011_111_001;
        step("mvoor_t0", 0, t0());
        step("mvoor_t1", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 4'd0, 16'd0, 4'd1, 0, 1, 0));

        // MVI R4
        ia.IR = 10'b0100_100_000;
        step("mvi_t0", 0, t0());
        step("mvi_t1", 0, mk(0, 1, 0, 0, 0, 0, 0, 2'b10, 4'd0, 16'd0, 4'd0, 0, 0, 0));
        step("mvi_t2", 0, mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd0, 16'h0010, 4'd0, 0, 1, 0));

        // illegal opcode 1101
        ia.IR = 10'b1101_000_000;
        step("ill_t0", 0, t0());
        step("ill_t1", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'd0, 4'd0, 0, 1, 1));

        // ADD with run dropped for 4 cycles at T2
        ia.IR = 10'b0101_001_010;
        step("addh_t0", 0, t0());
        step("addh_t1", 0, mk(0, 0, 0, 0, 0, 1, 0, 2'b01, 4'd0, 16'd0, 4'd1, 0, 0, 0));
        ia.run = 1'b0;
        for (int i = 0; i < 4; i++) step("addh_hold", 0, 36'd0);
        ia.run = 1'b1;
        step("addh_t2", 0, mk(0, 0, 0, 0, 1, 0, 0, 2'b01, 4'b0101, 16'd0, 4'd2, 0, 0, 0));
        step("addh_t3", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 4'd0, 16'h0002, 4'd0, 0, 1, 0));

        // reset during a LD stall
        ia.IR = 10'b0000_011_101; ia.mem_ready = 1'b0;
        step("ldr_t0", 0, t0());
        step("ldr_t1", 0, mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 4'd0, 16'd0, 4'd5, 0, 0, 0));
        step("ldr_stall", 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'd0, 4'd0, 1, 0, 0));
        reset = 1'b1; ia.mem_ready = 1'b1;
        step("ldr_rst", 0, 36'd0);
        reset = 1'b0;
        step("ldr_after", 0, t0());
        ia.run = 1'b0;

        // wide build, no memory wait: ADD R12,R3
        ib.run = 1'b1; ib.IR = 12'b0101_1100_0011;
        step("b_add_t0", 1, t0());
        step("b_add_t1", 1, mk(0, 0, 0, 0, 0, 1, 0, 2'b01, 4'd0, 16'd0, 4'd12, 0, 0, 0));
        step("b_add_t2", 1, mk(0, 0, 0, 0, 1, 0, 0, 2'b01, 4'b0101, 16'd0, 4'd3, 0, 0, 0));
        step("b_add_t3", 1, mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 4'd0, 16'h1000, 4'd0, 0, 1, 0));

        // ST R2,[R4] with mem_ready low (ignored): single write cycle
        ib.IR = 12'b0001_0010_0100;
        step("b_st_t0", 1, t0());
        step("b_st_t1", 1, mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 4'd0, 16'd0, 4'd4, 0, 0, 0));
        step("b_st_t2", 1, mk(0, 0, 1, 1, 0, 0, 0, 2'b01, 4'd0, 16'd0, 4'd2, 0, 1, 0));

        // MV R15,R1: index equals NREG, no write
        ib.IR = 12'b0011_1111_0001;
        step("b_mv_t0", 1, t0());
        step("b_mv_t1", 1, mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 4'd0, 16'd0, 4'd1, 0, 1, 0));
        step("b_next_t0", 1, t0());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
